rf_wport_arbiter: RTL and testbench

//  Shares the single regfile write port between the WB stage and one long-latency unit (LU: div/mul/csr).
//  LU results wait in a 1-entry holding buffer. WB has priority; the buffer is force-retired after MAX_WAIT cycles of waiting.

---
 rtl/rf_wport_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single regfile write port between the WB stage
// and one long-latency unit. LU results park in a 1-entry holding buffer; WB
// has priority, but after MAX_WAIT lost cycles WB is stalled for one cycle so
// the buffered result can retire.
module rf_wport_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_req_valid,
    input  logic [36:0] wb_req_bus,
    output logic        wb_req_ready,
    input  logic        lu_valid,
    input  logic [36:0] lu_bus,
    output logic        lu_ready,
    output logic [37:0] rf_wr_bus,
    output logic [36:0] lu_fwd,
    output logic        lu_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_buf_dest;
    logic [31:0]      r_buf_data;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             w_load;
    logic             w_buf_valid;
    logic             w_grant_wb;
    logic             w_grant_lu;
    logic             w_kill;
    logic [4:0]       w_wb_dest;

    // The buffer is occupied exactly when the FSM is out of IDLE, so the
    // valid flag is derived from the state rather than stored twice.
    assign w_buf_valid = (r_state != IDLE);
    assign w_wb_dest   = wb_req_bus[36:32];
    assign w_grant_wb  = wb_req_valid && (r_state != FORCE);
    assign w_grant_lu  = w_buf_valid && (!wb_req_valid || (r_state == FORCE));
    // A younger WB write to the same (non-r0) register makes the buffered
    // result dead; FORCE never kills because the LU writes first there.
    assign w_kill      = w_grant_wb && w_buf_valid && (w_wb_dest == r_buf_dest)
                         && (w_wb_dest != 5'd0);

    assign wb_req_ready = (r_state != FORCE);
    assign lu_ready     = resetn && !w_buf_valid;
    assign lu_busy      = w_buf_valid;
    assign lu_fwd       = {r_buf_dest & {5{w_buf_valid}}, r_buf_data};

    // Write-port mux: WB first, then the buffer, else an idle (all-zero) bus.
    always_comb begin
        rf_wr_bus = '0;
        if (resetn) begin
            if (w_grant_wb)
                rf_wr_bus = {1'b1, wb_req_bus};
            else if (w_grant_lu)
                rf_wr_bus = {1'b1, r_buf_dest, r_buf_data};
        end
    end

    // Next-state: accept into IDLE, retire/kill/age in PEND, one-shot FORCE.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                if (lu_valid && lu_ready) begin
                    w_state_nxt    = PEND;
                    w_wait_cnt_nxt = '0;
                    w_load         = 1'b1;
                end
            end
            PEND: begin
                if (w_grant_lu || w_kill) begin
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = '0;
                end else if (w_grant_wb) begin
                    if (r_wait_cnt == LAST_WAIT) begin
                        w_state_nxt    = FORCE;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                    end
                end
            end
            FORCE: begin
                w_state_nxt    = IDLE;
                w_wait_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt    = IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // State, wait counter and holding buffer; reset drops any buffered result.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_buf_dest <= '0;
            r_buf_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_load) begin
                r_buf_dest <= lu_bus[36:32];
                r_buf_data <= lu_bus[31:0];
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: a per-cycle vector table covering
// LU-only writes, starvation/FORCE, WAW kill, r0 handling and no-kill in FORCE,
// followed by hand-written reset sequences.
module tb_rf_wport_arbiter;

    logic        clk;
    logic        resetn;
    logic        wb_req_valid;
    logic [36:0] wb_req_bus;
    logic        wb_req_ready;
    logic        lu_valid;
    logic [36:0] lu_bus;
    logic        lu_ready;
    logic [37:0] rf_wr_bus;
    logic [36:0] lu_fwd;
    logic        lu_busy;

    int n_checks;
    int n_fail;

    localparam logic [36:0] NONE = 37'h0;
    localparam int NV = 25;

    typedef struct {
        logic        rst_n;
        logic        wv;
        logic [36:0] wb;
        logic        lv;
        logic [36:0] lb;
        logic        e_wrdy;
        logic        e_lrdy;
        logic [37:0] e_rf;
        logic [36:0] e_fwd;
        logic        e_busy;
    } vec_t;

    vec_t v[NV];

    rf_wport_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb_req_valid (wb_req_valid),
        .wb_req_bus   (wb_req_bus),
        .wb_req_ready (wb_req_ready),
        .lu_valid     (lu_valid),
        .lu_bus       (lu_bus),
        .lu_ready     (lu_ready),
        .rf_wr_bus    (rf_wr_bus),
        .lu_fwd       (lu_fwd),
        .lu_busy      (lu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst_n, input logic wv, input logic [36:0] wb,
                                input logic lv, input logic [36:0] lb,
                                input logic e_wrdy, input logic e_lrdy,
                                input logic [37:0] e_rf, input logic [36:0] e_fwd,
                                input logic e_busy);
        vec_t r;
        r.rst_n = rst_n; r.wv = wv; r.wb = wb; r.lv = lv; r.lb = lb;
        r.e_wrdy = e_wrdy; r.e_lrdy = e_lrdy; r.e_rf = e_rf; r.e_fwd = e_fwd;
        r.e_busy = e_busy;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [37:0] act,
                         input logic [37:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic e_wrdy, input logic e_lrdy,
                             input logic [37:0] e_rf, input logic [36:0] e_fwd,
                             input logic e_busy);
        check("wb_req_ready", idx, {37'h0, wb_req_ready}, {37'h0, e_wrdy});
        check("lu_ready",     idx, {37'h0, lu_ready},     {37'h0, e_lrdy});
        check("rf_wr_bus",    idx, rf_wr_bus,             e_rf);
        check("lu_fwd",       idx, {1'b0, lu_fwd},        {1'b0, e_fwd});
        check("lu_busy",      idx, {37'h0, lu_busy},      {37'h0, e_busy});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // rst wv wb lv lb | wrdy lrdy rf fwd busy
        v[0]  = mk(0, 0, NONE, 1, {5'd5, 32'hDEAD0001}, 1, 0, 38'h0, 37'h0, 0);
        v[1]  = mk(1, 0, NONE, 1, {5'd5, 32'hDEAD0001}, 1, 1, 38'h0, 37'h0, 0);
        v[2]  = mk(1, 0, NONE, 0, NONE, 1, 0, {1'b1, 5'd5, 32'hDEAD0001}, {5'd5, 32'hDEAD0001}, 1);
        v[3]  = mk(1, 0, NONE, 1, {5'd7, 32'h11}, 1, 1, 38'h0, {5'd0, 32'hDEAD0001}, 0);
        v[4]  = mk(1, 1, {5'd1, 32'h101}, 0, NONE, 1, 0, {1'b1, 5'd1, 32'h101}, {5'd7, 32'h11}, 1);
        v[5]  = mk(1, 1, {5'd2, 32'h102}, 0, NONE, 1, 0, {1'b1, 5'd2, 32'h102}, {5'd7, 32'h11}, 1);
        v[6]  = mk(1, 1, {5'd3, 32'h103}, 0, NONE, 1, 0, {1'b1, 5'd3, 32'h103}, {5'd7, 32'h11}, 1);
        v[7]  = mk(1, 1, {5'd4, 32'h104}, 0, NONE, 1, 0, {1'b1, 5'd4, 32'h104}, {5'd7, 32'h11}, 1);
        v[8]  = mk(1, 1, {5'd5, 32'h105}, 0, NONE, 0, 0, {1'b1, 5'd7, 32'h11}, {5'd7, 32'h11}, 1);
        v[9]  = mk(1, 1, {5'd5, 32'h105}, 0, NONE, 1, 1, {1'b1, 5'd5, 32'h105}, {5'd0, 32'h11}, 0);
        v[10] = mk(1, 0, NONE, 1, {5'd9, 32'hAA}, 1, 1, 38'h0, {5'd0, 32'h11}, 0);
        v[11] = mk(1, 1, {5'd9, 32'hBB}, 0, NONE, 1, 0, {1'b1, 5'd9, 32'hBB}, {5'd9, 32'hAA}, 1);
        v[12] = mk(1, 0, NONE, 0, NONE, 1, 1, 38'h0, {5'd0, 32'hAA}, 0);
        v[13] = mk(1, 0, NONE, 1, {5'd0, 32'h5}, 1, 1, 38'h0, {5'd0, 32'hAA}, 0);
        v[14] = mk(1, 1, {5'd0, 32'h6}, 0, NONE, 1, 0, {1'b1, 5'd0, 32'h6}, {5'd0, 32'h5}, 1);
        v[15] = mk(1, 0, NONE, 0, NONE, 1, 0, {1'b1, 5'd0, 32'h5}, {5'd0, 32'h5}, 1);
        v[16] = mk(1, 0, NONE, 0, NONE, 1, 1, 38'h0, {5'd0, 32'h5}, 0);
        v[17] = mk(1, 0, NONE, 1, {5'd4, 32'h44}, 1, 1, 38'h0, {5'd0, 32'h5}, 0);
        v[18] = mk(1, 1, {5'd1, 32'h201}, 0, NONE, 1, 0, {1'b1, 5'd1, 32'h201}, {5'd4, 32'h44}, 1);
        v[19] = mk(1, 1, {5'd1, 32'h202}, 0, NONE, 1, 0, {1'b1, 5'd1, 32'h202}, {5'd4, 32'h44}, 1);
        v[20] = mk(1, 1, {5'd1, 32'h203}, 0, NONE, 1, 0, {1'b1, 5'd1, 32'h203}, {5'd4, 32'h44}, 1);
        v[21] = mk(1, 1, {5'd1, 32'h204}, 0, NONE, 1, 0, {1'b1, 5'd1, 32'h204}, {5'd4, 32'h44}, 1);
        v[22] = mk(1, 1, {5'd4, 32'h55}, 0, NONE, 0, 0, {1'b1, 5'd4, 32'h44}, {5'd4, 32'h44}, 1);
        v[23] = mk(1, 1, {5'd4, 32'h55}, 0, NONE, 1, 1, {1'b1, 5'd4, 32'h55}, {5'd0, 32'h44}, 0);
        v[24] = mk(1, 0, NONE, 0, NONE, 1, 1, 38'h0, {5'd0, 32'h44}, 0);

        // First reset cycle: state is still unknown, only the reset-gated outputs are defined.
        resetn       = 1'b0;
        wb_req_valid = 1'b0;
        wb_req_bus   = NONE;
        lu_valid     = 1'b1;
        lu_bus       = {5'd5, 32'hDEAD0001};
        #1;
        check("rst_lu_ready", -1, {37'h0, lu_ready}, 38'h0);
        check("rst_we",       -1, {37'h0, rf_wr_bus[37]}, 38'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            resetn       = v[i].rst_n;
            wb_req_valid = v[i].wv;
            wb_req_bus   = v[i].wb;
            lu_valid     = v[i].lv;
            lu_bus       = v[i].lb;
            #1;
            check_all(i, v[i].e_wrdy, v[i].e_lrdy, v[i].e_rf, v[i].e_fwd, v[i].e_busy);
        end

        // Reset while a result is pending: it must be discarded and never written.
        @(negedge clk);
        lu_valid = 1'b1;
        lu_bus   = {5'd3, 32'h33};
        #1;
        check_all(100, 1'b1, 1'b1, 38'h0, {5'd0, 32'h44}, 1'b0);
        @(negedge clk);
        lu_valid = 1'b0;
        lu_bus   = NONE;
        resetn   = 1'b0;
        #1;
        check("midrst_rf",       101, rf_wr_bus, 38'h0);
        check("midrst_lu_ready", 101, {37'h0, lu_ready}, 38'h0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_all(102, 1'b1, 1'b1, 38'h0, 37'h0, 1'b0);
        @(negedge clk);
        #1;
        check_all(103, 1'b1, 1'b1, 38'h0, 37'h0, 1'b0);

        // WB writes during reset are suppressed at the write port.
        @(negedge clk);
        resetn       = 1'b0;
        wb_req_valid = 1'b1;
        wb_req_bus   = {5'd6, 32'h66};
        #1;
        check("rst_wb_we", 104, {37'h0, rf_wr_bus[37]}, 38'h0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("post_rst_wb", 105, rf_wr_bus, {1'b1, 5'd6, 32'h66});
        @(negedge clk);
        wb_req_valid = 1'b0;
        wb_req_bus   = NONE;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
